// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic {
        StInit,
        StRun
    } arb_state_e;

    typedef struct packed {
        logic [REG_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wr_fifo.sv
// Small synchronous FIFO with asynchronous active-low clear; Depth must be a power of two.
module wr_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop, full;

    assign full    = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-fill init sequence, then wb/multi-cycle
// arbitration with a buffered multi-cycle path, starvation stall and pending-write mask.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                mc_valid,
    output logic                mc_ready,
    input  logic [REG_W-1:0]    mc_reg,
    input  logic [DATA_W-1:0]   mc_data,
    input  logic                mc_issue,
    input  logic [REG_W-1:0]    mc_issue_reg,
    output logic                rf_RegWrite,
    output logic [REG_W-1:0]    rf_WriteReg,
    output logic [DATA_W-1:0]   rf_WriteData,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                stall_req,
    output logic                init_done
);

    localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    arb_state_e            state_q, state_d;
    logic [REG_W-1:0]      init_cnt_q, init_cnt_d;
    logic [StarveW-1:0]    starve_q, starve_d;
    logic                  stall_q;
    logic [NUM_REGS-1:0]   pend_q, pend_d;
    logic                  we_q, we_d;
    logic [REG_W-1:0]      wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    logic                  fifo_push, fifo_pop, fifo_empty;
    logic [CntW-1:0]       fifo_count;
    wr_req_t               fifo_in, fifo_head;

    logic                  wb_req, mc_accept, mc_nz, bypass;

    assign mc_ready  = (state_q == StRun) && (fifo_count < CntW'(FIFO_DEPTH));
    assign wb_req    = wb_valid && (wb_reg != REG_W'(ZERO_REG));
    assign mc_accept = mc_valid && mc_ready;
    assign mc_nz     = (mc_reg != REG_W'(ZERO_REG));
    assign bypass    = !wb_req && fifo_empty && mc_accept && mc_nz;
    assign fifo_in   = '{idx: mc_reg, data: mc_data};
    // Zero-register beats are accepted but never stored.
    assign fifo_push = mc_accept && mc_nz && !bypass;

    wr_fifo #(
        .Depth (FIFO_DEPTH),
        .Width ($bits(wr_req_t))
    ) u_wr_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_in),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        we_d       = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        pend_d     = pend_q;
        fifo_pop   = 1'b0;

        unique case (state_q)
            StInit: begin
                we_d    = (init_cnt_q != REG_W'(ZERO_REG));
                wreg_d  = init_cnt_q;
                wdata_d = '0;
                if (init_cnt_q == REG_W'(NUM_REGS - 1)) begin
                    state_d    = StRun;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + REG_W'(1);
                end
            end
            StRun: begin
                if (wb_req) begin
                    we_d    = 1'b1;
                    wreg_d  = wb_reg;
                    wdata_d = wb_data;
                    if (!fifo_empty && (starve_q != StarveW'(STARVE_LIMIT))) begin
                        starve_d = starve_q + StarveW'(1);
                    end
                end else if (!fifo_empty) begin
                    we_d                  = 1'b1;
                    wreg_d                = fifo_head.idx;
                    wdata_d               = fifo_head.data;
                    fifo_pop              = 1'b1;
                    starve_d              = '0;
                    pend_d[fifo_head.idx] = 1'b0;
                end else if (bypass) begin
                    we_d           = 1'b1;
                    wreg_d         = mc_reg;
                    wdata_d        = mc_data;
                    pend_d[mc_reg] = 1'b0;
                end
                // Applied after the clear so a same-cycle issue keeps the bit set.
                if (mc_issue && (mc_issue_reg != REG_W'(ZERO_REG))) begin
                    pend_d[mc_issue_reg] = 1'b1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            pend_q     <= '0;
            we_q       <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            starve_q   <= starve_d;
            stall_q    <= (starve_d == StarveW'(STARVE_LIMIT));
            pend_q     <= pend_d;
            we_q       <= we_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    assign rf_RegWrite  = we_q;
    assign rf_WriteReg  = wreg_q;
    assign rf_WriteData = wdata_q;
    assign pend_mask    = pend_q;
    assign stall_req    = stall_q;
    assign init_done    = (state_q == StRun);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus queues expected writes, a negedge monitor checks every rf write.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                wb_valid, mc_valid, mc_ready, mc_issue;
    logic [REG_W-1:0]    wb_reg, mc_reg, mc_issue_reg;
    logic [DATA_W-1:0]   wb_data, mc_data;
    logic                rf_RegWrite, stall_req, init_done;
    logic [REG_W-1:0]    rf_WriteReg;
    logic [DATA_W-1:0]   rf_WriteData;
    logic [NUM_REGS-1:0] pend_mask;

    typedef struct {
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_write_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .mc_valid     (mc_valid),
        .mc_ready     (mc_ready),
        .mc_reg       (mc_reg),
        .mc_data      (mc_data),
        .mc_issue     (mc_issue),
        .mc_issue_reg (mc_issue_reg),
        .rf_RegWrite  (rf_RegWrite),
        .rf_WriteReg  (rf_WriteReg),
        .rf_WriteData (rf_WriteData),
        .pend_mask    (pend_mask),
        .stall_req    (stall_req),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_wr(input int r, input logic [63:0] d);
        exp_t e;
        e.r = REG_W'(r);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
        mc_issue = 1'b0; mc_issue_reg = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_RegWrite"}, rf_RegWrite, 0);
        chk({tag, "_WriteReg"}, rf_WriteReg, 0);
        chk({tag, "_WriteData"}, rf_WriteData, 0);
        chk({tag, "_pend_mask"}, pend_mask, 0);
        chk({tag, "_stall_req"}, stall_req, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_mc_ready"}, mc_ready, 0);
    endtask

    // Monitor: every write the DUT presents must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b1 && rf_RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got X%0d=0x%0h expected no write at %0t",
                         rf_WriteReg, rf_WriteData, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_reg", rf_WriteReg, e.r);
                chk("wr_data", rf_WriteData, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");

        // Init sequence; pipeline inputs are active but must be ignored.
        for (int i = 1; i < 32; i++) expect_wr(i, 64'h0);
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 64'hFF;
        mc_valid = 1'b1; mc_reg = 5'd6; mc_data = 64'h1;
        mc_issue = 1'b1; mc_issue_reg = 5'd6;
        reset = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk("init_mc_ready", mc_ready, 0);
            chk("init_done_early", init_done, 0);
        end
        tick();
        idle();
        chk("init_done", init_done, 1);
        chk("init_pend_ignored", pend_mask, 0);
        chk("run_mc_ready", mc_ready, 1);
        tick();
        chk("run_idle_write", rf_RegWrite, 0);

        // Plain writeback, then hold of index/data when idle.
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 64'hDEADBEEF;
        expect_wr(5, 64'hDEADBEEF);
        tick();
        wb_valid = 1'b0;
        chk("wb_we", rf_RegWrite, 1);
        chk("wb_reg", rf_WriteReg, 5);
        chk("wb_data", rf_WriteData, 64'hDEADBEEF);
        tick();
        chk("idle_we", rf_RegWrite, 0);
        chk("hold_reg", rf_WriteReg, 5);
        chk("hold_data", rf_WriteData, 64'hDEADBEEF);

        // Pending bit for X7 cleared by the bypass write.
        mc_issue = 1'b1; mc_issue_reg = 5'd7;
        tick();
        mc_issue = 1'b0;
        chk("pend7_set", pend_mask, 32'h80);
        tick();
        chk("pend7_held", pend_mask, 32'h80);
        mc_valid = 1'b1; mc_reg = 5'd7; mc_data = 64'h1234;
        expect_wr(7, 64'h1234);
        chk("bypass_ready", mc_ready, 1);
        tick();
        mc_valid = 1'b0;
        chk("bypass_we", rf_RegWrite, 1);
        chk("bypass_reg", rf_WriteReg, 7);
        chk("pend7_clear", pend_mask, 0);

        // Starvation: wb every cycle while two mc beats wait in the FIFO.
        for (int i = 0; i < 6; i++) expect_wr(10 + i, 64'(160 + i));
        expect_wr(3, 64'h1);
        expect_wr(4, 64'h2);
        for (int i = 0; i < 6; i++) begin
            wb_valid = 1'b1; wb_reg = 5'(10 + i); wb_data = 64'(160 + i);
            if (i == 0) begin
                mc_valid = 1'b1; mc_reg = 5'd3; mc_data = 64'h1;
            end else if (i == 1) begin
                mc_valid = 1'b1; mc_reg = 5'd4; mc_data = 64'h2;
            end else begin
                mc_valid = 1'b0;
            end
            tick();
            chk("starve_stall", stall_req, (i >= 4));
            chk("starve_mc_ready", mc_ready, (i == 0));
        end
        idle();
        tick();
        chk("drain_stall", stall_req, 0);
        chk("drain_mc_ready", mc_ready, 1);
        chk("drain_first", rf_WriteReg, 3);
        tick();
        chk("drain_second", rf_WriteReg, 4);
        tick();
        chk("drain_idle", rf_RegWrite, 0);

        // Issue and FIFO-sourced write to X9 on the same edge: set wins.
        wb_valid = 1'b1; wb_reg = 5'd20; wb_data = 64'h2020;
        mc_valid = 1'b1; mc_reg = 5'd9; mc_data = 64'h99;
        mc_issue = 1'b1; mc_issue_reg = 5'd9;
        expect_wr(20, 64'h2020);
        expect_wr(9, 64'h99);
        tick();
        wb_valid = 1'b0; mc_valid = 1'b0;
        chk("pend9_set", pend_mask, 32'h200);
        tick();
        mc_issue = 1'b0;
        chk("fifo_x9_reg", rf_WriteReg, 9);
        chk("pend9_set_wins", pend_mask, 32'h200);
        tick();
        chk("pend9_held", pend_mask, 32'h200);
        mc_valid = 1'b1; mc_reg = 5'd9; mc_data = 64'h55;
        expect_wr(9, 64'h55);
        tick();
        mc_valid = 1'b0;
        chk("pend9_clear", pend_mask, 0);

        // Zero-register requests never reach the port or the mask.
        wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 64'hBAD;
        mc_issue = 1'b1; mc_issue_reg = 5'd0;
        tick();
        idle();
        chk("x0_wb_we", rf_RegWrite, 0);
        chk("x0_issue_pend", pend_mask, 0);
        chk("x0_hold_reg", rf_WriteReg, 9);
        mc_valid = 1'b1; mc_reg = 5'd0; mc_data = 64'hBAD;
        chk("x0_mc_ready", mc_ready, 1);
        tick();
        idle();
        chk("x0_mc_we", rf_RegWrite, 0);
        tick();
        chk("x0_not_queued", rf_RegWrite, 0);

        // Fill the FIFO with pend bit 7 set, then reset mid-operation.
        wb_valid = 1'b1; wb_reg = 5'd21; wb_data = 64'h21;
        mc_valid = 1'b1; mc_reg = 5'd22; mc_data = 64'h22;
        mc_issue = 1'b1; mc_issue_reg = 5'd7;
        expect_wr(21, 64'h21);
        expect_wr(23, 64'h23);
        tick();
        mc_issue = 1'b0;
        wb_reg = 5'd23; wb_data = 64'h23;
        mc_reg = 5'd24; mc_data = 64'h24;
        tick();
        idle();
        chk("prereset_full", mc_ready, 0);
        chk("prereset_pend", pend_mask, 32'h80);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        chk("queue_drained", exp_q.size(), 0);
        tick();
        tick();
        for (int i = 1; i < 32; i++) expect_wr(i, 64'h0);
        reset = 1'b1;
        repeat (40) tick();
        chk("reinit_done", init_done, 1);
        chk("reinit_pend", pend_mask, 0);
        chk("reinit_idle", rf_RegWrite, 0);
        chk("reinit_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
